// File: rtl/wb_arb_pkg.sv
// Shared constants and side encoding for the register-file writeback port arbiter.
package wb_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the loser after each grant.
module rr_arb2
  import wb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  side_e r_prio;

  // NOTE: gnt gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (r_prio == SIDE_A) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)       r_prio <= SIDE_A;
    else if (|gnt)   r_prio <= gnt[0] ? SIDE_B : SIDE_A;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback,
// with a one-deep output stage, x0 discard, write-port freeze and a stall counter.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              wr_block,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] busW,
  output logic              reg_wr,
  output logic [CNT_W-1:0]  wait_cnt
);

  logic              r_stg_valid;
  logic [ADDR_W-1:0] r_stg_addr;
  logic [DATA_W-1:0] r_stg_data;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic       w_a_zero, w_b_zero, w_a_nz, w_b_nz;
  logic       w_can_accept, w_stall;
  logic [1:0] w_gnt;

  assign w_a_zero = a_valid && (a_addr == ADDR_W'(ZERO_REG));
  assign w_b_zero = b_valid && (b_addr == ADDR_W'(ZERO_REG));
  assign w_a_nz   = a_valid && !w_a_zero;
  assign w_b_nz   = b_valid && !w_b_zero;

  // The stage can take a new write when empty or when it drains this cycle.
  assign w_can_accept = !r_stg_valid || !wr_block;

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   ({w_b_nz, w_a_nz}),
    .en    (w_can_accept && !reset),
    .gnt   (w_gnt)
  );

  // x0 writes are acknowledged immediately and never occupy the port.
  assign a_ready = !reset && (w_a_zero || w_gnt[0]);
  assign b_ready = !reset && (w_b_zero || w_gnt[1]);

  assign w_stall = (w_a_nz && !w_gnt[0]) || (w_b_nz && !w_gnt[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_data  <= '0;
    end else if (w_gnt[0]) begin
      r_stg_valid <= 1'b1;
      r_stg_addr  <= a_addr;
      r_stg_data  <= a_data;
    end else if (w_gnt[1]) begin
      r_stg_valid <= 1'b1;
      r_stg_addr  <= b_addr;
      r_stg_data  <= b_data;
    end else if (!wr_block) begin
      r_stg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                               r_wait_cnt <= '0;
    else if (w_stall && (r_wait_cnt != '1))  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  // Outputs are forced low while reset is held, even before the stage clears.
  assign reg_wr   = !reset && r_stg_valid && !wr_block;
  assign rd       = reset ? '0 : r_stg_addr;
  assign busW     = reset ? '0 : r_stg_data;
  assign wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector table plus randomized traffic checked against a behavioural model.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, wr_block;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, reg_wr;
  logic [4:0]  rd;
  logic [31:0] busW;
  logic [15:0] wait_cnt;
  logic        s_a_ready, s_b_ready, s_reg_wr;
  logic [4:0]  s_rd;
  logic [31:0] s_busW;
  logic [1:0]  s_wait_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_block(wr_block), .rd(rd), .busW(busW), .reg_wr(reg_wr), .wait_cnt(wait_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(s_b_ready),
    .wr_block(wr_block), .rd(s_rd), .busW(s_busW), .reg_wr(s_reg_wr), .wait_cnt(s_wait_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        bv; logic [4:0] ba; logic [31:0] bd;
    logic        blk;
    logic        ea, eb, ew;
    logic [4:0]  erd;
    logic [31:0] ebus;
    int          ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic vec(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd, input logic blk,
                     input logic ea, input logic eb, input logic ew,
                     input logic [4:0] erd, input logic [31:0] ebus, input int ecnt);
    vec_t v;
    v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.blk = blk; v.ea = ea; v.eb = eb; v.ew = ew; v.erd = erd; v.ebus = ebus; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  function automatic int sat3(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  // Behavioural model: one pending-write slot, favoured side, stall count, register-file images.
  logic        m_pend;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_fav;
  int          m_cnt;
  logic [31:0] exp_rf [32];
  logic [31:0] dut_rf [32];
  logic        a_hs, b_hs;

  task automatic model_reset();
    m_pend = 1'b0; m_addr = '0; m_data = '0; m_fav = 0; m_cnt = 0;
    a_hs = 1'b0; b_hs = 1'b0;
    for (int i = 0; i < 32; i++) begin exp_rf[i] = '0; dut_rf[i] = '0; end
  endtask

  task automatic model_cycle();
    logic a_nz, b_nz, acc, ga, gb, ea, eb;
    a_nz = a_valid && (a_addr != 0);
    b_nz = b_valid && (b_addr != 0);
    acc  = !m_pend || !wr_block;
    ga   = acc && a_nz && (!b_nz || m_fav == 0);
    gb   = acc && b_nz && (!a_nz || m_fav == 1);
    ea   = (a_valid && a_addr == 0) || ga;
    eb   = (b_valid && b_addr == 0) || gb;
    check("rnd_a_ready", a_ready, ea);
    check("rnd_b_ready", b_ready, eb);
    check("rnd_reg_wr", reg_wr, m_pend && !wr_block);
    check("rnd_rd", rd, m_addr);
    check("rnd_busW", busW, m_data);
    check("rnd_wait_cnt", wait_cnt, m_cnt);
    check("rnd_sat_cnt", s_wait_cnt, sat3(m_cnt));
    if (reg_wr) dut_rf[rd] = busW;
    a_hs = a_valid && ea;
    b_hs = b_valid && eb;
    if (((a_nz && !ga) || (b_nz && !gb)) && m_cnt < 65535) m_cnt++;
    if (ga) begin
      m_pend = 1'b1; m_addr = a_addr; m_data = a_data; exp_rf[a_addr] = a_data; m_fav = 1;
    end else if (gb) begin
      m_pend = 1'b1; m_addr = b_addr; m_data = b_data; exp_rf[b_addr] = b_data; m_fav = 0;
    end else if (!wr_block) begin
      m_pend = 1'b0;
    end
  endtask

  initial begin
    //   rst av aa ad            bv ba bd        blk ea eb ew erd ebus          cnt
    vec(0, 1, 3, 32'hDEADBEEF, 0, 0, 32'h0,  0, 1, 0, 0, 0,  32'h0,        0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 1, 3,  32'hDEADBEEF, 0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 3,  32'hDEADBEEF, 0);
    vec(1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 0,  32'h0,        0);
    vec(0, 1, 1, 32'h11,       1, 2, 32'h22, 0, 1, 0, 0, 0,  32'h0,        0);
    vec(0, 1, 1, 32'h13,       1, 2, 32'h22, 0, 0, 1, 1, 1,  32'h11,       1);
    vec(0, 1, 1, 32'h13,       1, 2, 32'h24, 0, 1, 0, 1, 2,  32'h22,       2);
    vec(0, 1, 1, 32'h15,       1, 2, 32'h24, 0, 0, 1, 1, 1,  32'h13,       3);
    vec(0, 1, 1, 32'h15,       0, 0, 32'h0,  0, 1, 0, 1, 2,  32'h24,       4);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 1, 1,  32'h15,       4);
    vec(0, 0, 0, 32'h0,        1, 3, 32'h33, 0, 0, 1, 0, 1,  32'h15,       4);
    vec(0, 1, 0, 32'h99,       1, 7, 32'h77, 0, 1, 1, 1, 3,  32'h33,       4);
    vec(0, 1, 4, 32'h44,       1, 6, 32'h66, 0, 1, 0, 1, 7,  32'h77,       4);
    vec(0, 0, 0, 32'h0,        1, 6, 32'h66, 0, 0, 1, 1, 4,  32'h44,       5);
    vec(0, 1, 5, 32'h55,       0, 0, 32'h0,  0, 1, 0, 1, 6,  32'h66,       5);
    vec(0, 1, 8, 32'h88,       1, 10, 32'hAA, 1, 0, 0, 0, 5, 32'h55,       5);
    vec(0, 1, 8, 32'h88,       1, 10, 32'hAA, 1, 0, 0, 0, 5, 32'h55,       6);
    vec(0, 1, 8, 32'h88,       1, 10, 32'hAA, 1, 0, 0, 0, 5, 32'h55,       7);
    vec(0, 1, 8, 32'h88,       1, 10, 32'hAA, 0, 0, 1, 1, 5, 32'h55,       8);
    vec(0, 1, 8, 32'h88,       0, 0, 32'h0,  0, 1, 0, 1, 10, 32'hAA,       9);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 1, 8,  32'h88,       9);
    vec(0, 0, 0, 32'h0,        1, 3, 32'h33, 0, 0, 1, 0, 8,  32'h88,       9);
    vec(0, 1, 9, 32'h1,        1, 9, 32'h2,  0, 1, 0, 1, 3,  32'h33,       9);
    vec(0, 0, 0, 32'h0,        1, 9, 32'h2,  0, 0, 1, 1, 9,  32'h1,       10);
    vec(0, 1, 12, 32'hC,       0, 0, 32'h0,  0, 1, 0, 1, 9,  32'h2,       10);
    vec(1, 1, 13, 32'hD,       1, 0, 32'hE,  0, 0, 0, 0, 0,  32'h0,       10);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 0,  32'h0,        0);
    vec(0, 1, 2, 32'h20,       0, 0, 32'h0,  1, 1, 0, 0, 0,  32'h0,        0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 2,  32'h20,       0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 1, 2,  32'h20,       0);
    vec(0, 1, 11, 32'hB1,      0, 0, 32'h0,  0, 1, 0, 0, 2,  32'h20,       0);
    vec(0, 1, 0, 32'h5,        1, 14, 32'hE, 1, 1, 0, 0, 11, 32'hB1,       0);
    vec(0, 0, 0, 32'h0,        1, 14, 32'hE, 0, 0, 1, 1, 11, 32'hB1,       1);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 1, 14, 32'hE,        1);

    reset = 1'b1; a_valid = 0; b_valid = 0; wr_block = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_reg_wr", reg_wr, 0);
    check("reset_rd", rd, 0);
    check("reset_busW", busW, 0);
    check("reset_wait_cnt", wait_cnt, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      reset = vecs[i].rst; wr_block = vecs[i].blk;
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      #1;
      check($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ea);
      check($sformatf("v%0d_b_ready", i), b_ready, vecs[i].eb);
      check($sformatf("v%0d_reg_wr", i), reg_wr, vecs[i].ew);
      check($sformatf("v%0d_rd", i), rd, vecs[i].erd);
      check($sformatf("v%0d_busW", i), busW, vecs[i].ebus);
      check($sformatf("v%0d_wait_cnt", i), wait_cnt, vecs[i].ecnt);
      check($sformatf("v%0d_sat_cnt", i), s_wait_cnt, sat3(vecs[i].ecnt));
      @(posedge clk); #1;
    end

    reset = 1'b1; a_valid = 0; b_valid = 0; wr_block = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc < 2990) begin
        if (!a_valid || a_hs) begin
          a_valid = ($urandom_range(0, 2) != 0);
          a_addr  = 5'($urandom_range(0, 7));
          a_data  = $urandom;
        end
        if (!b_valid || b_hs) begin
          b_valid = ($urandom_range(0, 2) != 0);
          b_addr  = 5'($urandom_range(0, 7));
          b_data  = $urandom;
        end
        wr_block = ($urandom_range(0, 3) == 0);
      end else begin
        a_valid = 0; b_valid = 0; wr_block = 0;
      end
      #1;
      model_cycle();
      @(posedge clk); #1;
    end

    for (int r = 0; r < 32; r++) check($sformatf("rf_x%0d", r), dut_rf[r], exp_rf[r]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
